// File: rtl/inference_ctrl_pkg.sv
// nn_ctrl_pkg: shared state encoding and width helpers for the inference sequencer
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      WAIT_NET,
      WAIT_MAX,
      DONE
   } ctrl_state_t;

   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int TIMEOUT_W = $clog2(DEF_TIMEOUT_CYCLES + 1);

   function automatic int timeout_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   function automatic int class_w(input int classes);
      return (classes > 1) ? $clog2(classes) : 1;
   endfunction

endpackage

// File: rtl/inference_ctrl_valid_delay.sv
// valid_delay: fixed-latency shift register with synchronous flush for read-side strobes
module valid_delay #(
   parameter int LAT = 1,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [LAT*W-1:0] sr_q, sr_d;

   // shift one stage per cycle; flush empties every stage at once
   always_comb sr_d = flush ? '0 : (LAT*W)'({sr_q, din});

   // stage register
   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign dout = sr_q[LAT*W-1 -: W];

endmodule

// File: rtl/inference_ctrl.sv
// inference_ctrl: sequences pixel streaming, network/argmax waits and result capture for one inference
module inference_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int numPixels     = 784,
   parameter int addrWidth     = 10,
   parameter int memLatency    = 1,
   parameter int numClasses    = 10,
   parameter int timeoutCycles = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [addrWidth-1:0]          imgBase,
   output logic                          busy,
   output logic                          imgRdEn,
   output logic [addrWidth-1:0]          imgAddr,
   output logic                          pixelValid,
   output logic                          pixelLast,
   input  logic                          netOutValid,
   input  logic                          maxValid,
   input  logic [31:0]                   maxIdx,
   output logic [class_w(numClasses)-1:0] digit,
   output logic                          done,
   output logic                          err
);

   localparam int CW = class_w(numClasses);
   localparam int PW = $clog2(numPixels + 1);
   localparam int TW = timeout_w(timeoutCycles);
   localparam logic [PW-1:0] LAST_PIX  = PW'(numPixels - 1);
   localparam logic [PW-1:0] DRAIN_END = PW'(memLatency - 1);
   localparam logic [TW-1:0] TMO_END   = TW'(timeoutCycles - 1);

   ctrl_state_t          state_q, state_d;
   logic [addrWidth-1:0] base_q, base_d;
   logic [PW-1:0]        ctr_q, ctr_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [CW-1:0]        digit_q, digit_d;
   logic                 err_q, err_d;
   logic                 abort;
   logic [1:0]           dly_out;

   // next-state: pixel/drain counting shares ctr, wait states share the timeout counter
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      ctr_d   = ctr_q;
      tmo_d   = '0;
      digit_d = digit_q;
      err_d   = err_q;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               base_d  = imgBase;
               err_d   = 1'b0;
               ctr_d   = '0;
            end
         end
         FETCH, DRAIN: begin
            if (netOutValid) begin
               abort   = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (state_q == FETCH) begin
               ctr_d   = (ctr_q == LAST_PIX) ? '0 : ctr_q + 1'b1;
               state_d = (ctr_q == LAST_PIX) ? DRAIN : FETCH;
            end else begin
               ctr_d   = (ctr_q == DRAIN_END) ? '0 : ctr_q + 1'b1;
               state_d = (ctr_q == DRAIN_END) ? WAIT_NET : DRAIN;
            end
         end
         WAIT_NET: begin
            if (netOutValid) state_d = WAIT_MAX;
            else if (tmo_q == TMO_END) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else tmo_d = tmo_q + 1'b1;
         end
         WAIT_MAX: begin
            if (maxValid && maxIdx < 32'(numClasses)) begin
               digit_d = maxIdx[CW-1:0];
               state_d = DONE;
            end else if (maxValid || tmo_q == TMO_END) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else tmo_d = tmo_q + 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         ctr_q   <= '0;
         tmo_q   <= '0;
         digit_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         ctr_q   <= ctr_d;
         tmo_q   <= tmo_d;
         digit_q <= digit_d;
         err_q   <= err_d;
      end
   end

   assign imgRdEn = (state_q == FETCH);
   assign imgAddr = imgRdEn ? base_q + addrWidth'(ctr_q) : '0;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign err     = err_q;
   assign digit   = digit_q;

   valid_delay #(.LAT(memLatency), .W(2)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .flush(abort),
      .din  ({imgRdEn, imgRdEn && ctr_q == LAST_PIX}),
      .dout (dly_out)
   );

   assign pixelValid = dly_out[1];
   assign pixelLast  = dly_out[0];

endmodule

// File: tb/tb_inference_ctrl.sv
// tb_inference_ctrl: randomized scoreboard bench for the inference sequencer
module tb_inference_ctrl;

   localparam int N  = 40;
   localparam int AW = 6;
   localparam int L  = 3;
   localparam int NC = 10;
   localparam int TO = 16;
   localparam int CW = $clog2(NC);

   typedef struct {
      logic [AW-1:0] addr;
      logic          last;
   } rd_t;

   typedef struct {
      int   cyc;
      logic last;
   } pv_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] imgBase = '0;
   logic          netOutValid = 1'b0;
   logic          maxValid = 1'b0;
   logic [31:0]   maxIdx = '0;
   logic          busy, imgRdEn, pixelValid, pixelLast, done, err;
   logic [AW-1:0] imgAddr;
   logic [CW-1:0] digit;

   rd_t exp_rd[$];
   pv_t exp_pv[$];
   int  exp_dig[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int first_rd = 0;
   int last_rd = 0;
   int model_digit = 0;
   bit got_last = 1'b0;

   inference_ctrl #(
      .numPixels(N), .addrWidth(AW), .memLatency(L), .numClasses(NC), .timeoutCycles(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .imgBase(imgBase), .busy(busy),
      .imgRdEn(imgRdEn), .imgAddr(imgAddr), .pixelValid(pixelValid), .pixelLast(pixelLast),
      .netOutValid(netOutValid), .maxValid(maxValid), .maxIdx(maxIdx),
      .digit(digit), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: every read, pixel strobe and done pulse is matched against the scoreboard
   always @(negedge clk) begin : mon
      rd_t r;
      pv_t p;
      if (imgRdEn) begin
         if (exp_rd.size() == 0) chk("stray_read", imgRdEn, 0);
         else begin
            r = exp_rd.pop_front();
            chk("rd_addr", imgAddr, r.addr);
            exp_pv.push_back('{cyc + L, r.last});
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
         end
      end
      if (pixelValid) begin
         if (exp_pv.size() == 0) chk("stray_pixel", pixelValid, 0);
         else begin
            p = exp_pv.pop_front();
            chk("pv_cycle", cyc, p.cyc);
            chk("pv_last", pixelLast, p.last);
            if (p.last) got_last = 1'b1;
         end
      end else if (pixelLast) chk("last_wo_valid", pixelLast, 0);
      if (done) begin
         if (exp_dig.size() == 0) chk("stray_done", done, 0);
         else chk("done_digit", digit, exp_dig.pop_front());
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input int base);
      start   = 1'b1;
      imgBase = AW'(base);
      step();
      start = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rden"}, imgRdEn, 0);
      chk({tag, "_addr"}, imgAddr, 0);
      chk({tag, "_pv"}, pixelValid, 0);
      chk({tag, "_plast"}, pixelLast, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_digit"}, digit, 0);
   endtask

   task automatic start_run(input int base);
      for (int i = 0; i < N; i++) exp_rd.push_back('{AW'((base + i) % (1 << AW)), i == N - 1});
      rd_cnt   = 0;
      got_last = 1'b0;
      chk("idle_busy", busy, 0);
      pulse_start(base);
      chk("busy_rise", busy, 1);
      chk("err_clear", err, 0);
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (!got_last && n < 4 * N) begin
         step();
         n++;
      end
      chk("fetch_done", got_last, 1);
      chk("fetch_span", last_rd - first_rd, N - 1);
      step();
   endtask

   task automatic pulse_net();
      netOutValid = 1'b1;
      step();
      netOutValid = 1'b0;
   endtask

   task automatic run_full(input int base, input bit interfere);
      int idx;
      int n = 0;
      start_run(base);
      if (interfere) begin
         repeat (5) step();
         pulse_start((base + 7) % (1 << AW));
         chk("busy_hold", busy, 1);
      end
      wait_fetch();
      if (interfere) begin
         maxIdx   = 3;
         maxValid = 1'b1;
         step();
         maxValid = 1'b0;
         chk("max_ignored", busy, 1);
      end
      repeat ($urandom_range(0, 5)) step();
      pulse_net();
      repeat ($urandom_range(0, 5)) step();
      idx = int'($urandom_range(0, NC - 1));
      exp_dig.push_back(idx);
      model_digit = idx;
      maxIdx      = idx;
      maxValid    = 1'b1;
      step();
      maxValid = 1'b0;
      while (exp_dig.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk("done_seen", exp_dig.size(), 0);
      step();
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_err", err, 0);
      chk("post_digit", digit, model_digit);
   endtask

   task automatic wait_reads(input int k);
      int n = 0;
      while (rd_cnt < k && n < 4 * N) begin
         step();
         n++;
      end
   endtask

   initial begin
      start = 1'b1;
      repeat (2) step();
      check_reset("reset");
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("rst_wins", busy, 0);

      run_full(0, 0);
      run_full(50, 0);
      for (int i = 0; i < 4; i++) run_full(int'($urandom_range(0, (1 << AW) - 1)), 0);

      start_run(5);
      wait_fetch();
      for (int k = 1; k <= TO; k++) begin
         step();
         chk("tmo_err", err, k == TO);
         chk("tmo_busy", busy, k < TO);
      end
      run_full(9, 0);

      start_run(20);
      wait_reads(10);
      netOutValid = 1'b1;
      exp_rd.delete();
      exp_pv.delete();
      step();
      netOutValid = 1'b0;
      chk("abort_err", err, 1);
      chk("abort_rden", imgRdEn, 0);
      chk("abort_busy", busy, 0);
      chk("abort_reads", rd_cnt, 10);
      repeat (L + 3) step();

      run_full(33, 0);
      if (model_digit == 0) run_full(34, 0);
      start_run(12);
      wait_fetch();
      pulse_net();
      maxIdx   = 12;
      maxValid = 1'b1;
      step();
      maxValid = 1'b0;
      chk("badidx_err", err, 1);
      chk("badidx_busy", busy, 0);
      chk("badidx_digit", digit, model_digit);
      repeat (3) step();

      run_full(60, 1);

      start_run(40);
      wait_reads(25);
      rst = 1'b1;
      exp_rd.delete();
      exp_pv.delete();
      model_digit = 0;
      step();
      check_reset("midrst");
      rst = 1'b0;
      repeat (L + 3) step();

      run_full(17, 0);

      chk("rd_queue_empty", exp_rd.size(), 0);
      chk("pv_queue_empty", exp_pv.size(), 0);
      chk("dig_queue_empty", exp_dig.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
